// File: rtl/focus_peak_track.sv
// Focus sharpness history buffer and autofocus-sweep peak detector.
// Optional macro FOCUS_PEAK_DELTA_EN adds the delta/delta_valid sample-difference outputs.
module focus_peak_track #(
  parameter int AW   = 4,
  parameter int FN_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [31:0]     hifreq,
  input  logic            hifreq_stb,
  input  logic            arm,
  input  logic [2:0]      drop_shift,
  input  logic            rd_en,
  input  logic [AW-1:0]   rd_addr,
  output logic [31:0]     rd_data,
  output logic            rd_valid,
  output logic [AW:0]     count,
  output logic [FN_W-1:0] frame_num,
  output logic [31:0]     peak_val,
  output logic [FN_W-1:0] peak_frame,
  output logic            busy,
  output logic            peak_passed,
  output logic            done
`ifdef FOCUS_PEAK_DELTA_EN
  ,
  output logic [32:0]     delta,
  output logic            delta_valid
`endif
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] DEPTH_C = {1'b1, {AW{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARMED  = 2'd1,
    S_RISING = 2'd2,
    S_PASSED = 2'd3
  } state_t;

  state_t          state_r, state_nxt_s;
  logic [31:0]     mem_r [0:DEPTH-1];
  logic [AW-1:0]   wp_r;
  logic [AW-1:0]   phys_s;
  logic [AW:0]     count_r;
  logic [FN_W-1:0] frame_num_r;
  logic [31:0]     rd_data_r;
  logic            rd_valid_r;
  logic [31:0]     peak_val_r, peak_val_nxt_s;
  logic [FN_W-1:0] peak_frame_r, peak_frame_nxt_s;
  logic            passed_r, passed_nxt_s;
  logic            done_r, done_nxt_s;
  logic            busy_r;
  logic            acc_s;
  logic [31:0]     thresh_s;
  logic            drop_s;

  assign acc_s    = hifreq_stb && en;
  // Newest entry sits one behind the write pointer.
  assign phys_s   = wp_r - {{(AW-1){1'b0}}, 1'b1} - rd_addr;
  assign thresh_s = peak_val_r - (peak_val_r >> drop_shift);
  assign drop_s   = (drop_shift != 3'd0) && (hifreq < thresh_s);

  // History RAM write port, not cleared by reset
  always_ff @(posedge clk) begin
    if (acc_s && !rst) begin
      mem_r[wp_r] <= hifreq;
    end
  end

  // Write pointer, fill count, frame counter and registered readout
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_r        <= {AW{1'b0}};
      count_r     <= {(AW+1){1'b0}};
      frame_num_r <= {FN_W{1'b0}};
      rd_data_r   <= 32'd0;
      rd_valid_r  <= 1'b0;
    end else begin
      rd_valid_r <= rd_en;
      if (rd_en) begin
        rd_data_r <= ({1'b0, rd_addr} < count_r) ? mem_r[phys_s] : 32'd0;
      end
      if (acc_s) begin
        wp_r        <= wp_r + {{(AW-1){1'b0}}, 1'b1};
        frame_num_r <= frame_num_r + {{(FN_W-1){1'b0}}, 1'b1};
        if (count_r != DEPTH_C) begin
          count_r <= count_r + {{AW{1'b0}}, 1'b1};
        end
      end
    end
  end

  // FSM state register and registered sweep outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= S_IDLE;
      peak_val_r   <= 32'd0;
      peak_frame_r <= {FN_W{1'b0}};
      passed_r     <= 1'b0;
      done_r       <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      peak_val_r   <= peak_val_nxt_s;
      peak_frame_r <= peak_frame_nxt_s;
      passed_r     <= passed_nxt_s;
      done_r       <= done_nxt_s;
      busy_r       <= (state_nxt_s == S_ARMED) || (state_nxt_s == S_RISING);
    end
  end

  // FSM next-state logic; arm restarts from any state
  always_comb begin
    state_nxt_s = state_r;
    if (arm) begin
      state_nxt_s = acc_s ? S_RISING : S_ARMED;
    end else begin
      case (state_r)
        S_ARMED: begin
          if (acc_s) state_nxt_s = S_RISING;
          else       state_nxt_s = S_ARMED;
        end
        S_RISING: begin
          if (acc_s && drop_s) state_nxt_s = S_PASSED;
          else                 state_nxt_s = S_RISING;
        end
        S_IDLE:   state_nxt_s = S_IDLE;
        S_PASSED: state_nxt_s = S_PASSED;
        default:  state_nxt_s = S_IDLE;
      endcase
    end
  end

  // Peak tracking, pass flag and done pulse; equal samples keep the earliest frame
  always_comb begin
    peak_val_nxt_s   = peak_val_r;
    peak_frame_nxt_s = peak_frame_r;
    passed_nxt_s     = passed_r;
    done_nxt_s       = 1'b0;
    if (arm) begin
      passed_nxt_s = 1'b0;
      if (acc_s) begin
        peak_val_nxt_s   = hifreq;
        peak_frame_nxt_s = frame_num_r;
      end else begin
        peak_val_nxt_s   = 32'd0;
        peak_frame_nxt_s = {FN_W{1'b0}};
      end
    end else begin
      case (state_r)
        S_ARMED: begin
          if (acc_s) begin
            peak_val_nxt_s   = hifreq;
            peak_frame_nxt_s = frame_num_r;
          end else begin
            peak_val_nxt_s   = peak_val_r;
            peak_frame_nxt_s = peak_frame_r;
          end
        end
        S_RISING: begin
          if (acc_s && (hifreq > peak_val_r)) begin
            peak_val_nxt_s   = hifreq;
            peak_frame_nxt_s = frame_num_r;
          end else if (acc_s && drop_s) begin
            passed_nxt_s = 1'b1;
            done_nxt_s   = 1'b1;
          end else begin
            done_nxt_s = 1'b0;
          end
        end
        default: begin
          done_nxt_s = 1'b0;
        end
      endcase
    end
  end

`ifdef FOCUS_PEAK_DELTA_EN
  logic [31:0] prev_r;
  logic [32:0] delta_r;
  logic        delta_valid_r;

  // Difference between consecutive accepted samples
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_r        <= 32'd0;
      delta_r       <= 33'd0;
      delta_valid_r <= 1'b0;
    end else if (acc_s) begin
      prev_r <= hifreq;
      if (count_r != {(AW+1){1'b0}}) begin
        delta_r       <= {1'b0, hifreq} - {1'b0, prev_r};
        delta_valid_r <= 1'b1;
      end else begin
        delta_r       <= 33'd0;
        delta_valid_r <= 1'b0;
      end
    end
  end

  assign delta       = delta_r;
  assign delta_valid = delta_valid_r;
`endif

  assign rd_data     = rd_data_r;
  assign rd_valid    = rd_valid_r;
  assign count       = count_r;
  assign frame_num   = frame_num_r;
  assign peak_val    = peak_val_r;
  assign peak_frame  = peak_frame_r;
  assign busy        = busy_r;
  assign peak_passed = passed_r;
  assign done        = done_r;

endmodule

// File: tb/tb_focus_peak_track.sv
// Scoreboard bench for focus_peak_track: driver pushes model expectations, monitor pops and compares.
// Honours FOCUS_PEAK_DELTA_EN to also check delta/delta_valid.
module tb_focus_peak_track;
  localparam int AW = 4;
  localparam int FN_W = 16;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst = 1'b1;
  logic            en = 1'b0;
  logic [31:0]     hifreq = 32'd0;
  logic            hifreq_stb = 1'b0;
  logic            arm = 1'b0;
  logic [2:0]      drop_shift = 3'd0;
  logic            rd_en = 1'b0;
  logic [AW-1:0]   rd_addr = '0;
  logic [31:0]     rd_data;
  logic            rd_valid;
  logic [AW:0]     count;
  logic [FN_W-1:0] frame_num;
  logic [31:0]     peak_val;
  logic [FN_W-1:0] peak_frame;
  logic            busy, peak_passed, done;
`ifdef FOCUS_PEAK_DELTA_EN
  logic [32:0]     delta;
  logic            delta_valid;
`endif

  focus_peak_track #(.AW(AW), .FN_W(FN_W)) dut (
    .clk(clk), .rst(rst), .en(en), .hifreq(hifreq), .hifreq_stb(hifreq_stb),
    .arm(arm), .drop_shift(drop_shift), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid), .count(count), .frame_num(frame_num),
    .peak_val(peak_val), .peak_frame(peak_frame), .busy(busy),
    .peak_passed(peak_passed), .done(done)
`ifdef FOCUS_PEAK_DELTA_EN
    , .delta(delta), .delta_valid(delta_valid)
`endif
  );

  typedef struct {
    int unsigned count, fn, pv, pf;
    bit busy, passed, done, rv;
    logic [32:0] delta;
    bit dv;
  } exp_t;

  exp_t        sq[$];
  logic [31:0] rq[$];
  int n_vec = 0;
  int n_err = 0;

  // Reference model state: history newest-first, plus the sweep's abstract status
  int unsigned hist[$];
  int unsigned m_fn = 0;
  bit          m_busy = 0, m_have = 0, m_passed = 0;
  int unsigned m_peak = 0, m_pf = 0;
  logic [32:0] m_delta = 33'd0;
  bit          m_dv = 0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  task automatic cyc(input bit r, input bit e, input bit s, input logic [31:0] v,
                     input bit a, input logic [2:0] d, input bit re, input logic [3:0] ra);
    exp_t x;
    bit acc;
    @(negedge clk);
    rst = r; en = e; hifreq_stb = s; hifreq = v; arm = a; drop_shift = d;
    rd_en = re; rd_addr = ra;
    x.done = 0;
    if (r) begin
      hist.delete(); m_fn = 0; m_busy = 0; m_have = 0; m_passed = 0;
      m_peak = 0; m_pf = 0; m_delta = 33'd0; m_dv = 0; x.rv = 0;
    end else begin
      x.rv = re;
      if (re) rq.push_back((int'(ra) < hist.size()) ? hist[ra] : 32'd0);
      acc = s && e;
      if (a) begin
        m_passed = 0; m_busy = 1;
        if (acc) begin m_have = 1; m_peak = v; m_pf = m_fn; end
        else begin m_have = 0; m_peak = 0; m_pf = 0; end
      end else if (m_busy && acc) begin
        if (!m_have) begin m_have = 1; m_peak = v; m_pf = m_fn; end
        else if (v > m_peak) begin m_peak = v; m_pf = m_fn; end
        else if (d != 0 && v < m_peak - (m_peak >> d)) begin
          m_busy = 0; m_passed = 1; x.done = 1;
        end
      end
      if (acc) begin
        if (hist.size() > 0) begin
          m_delta = 33'(longint'(v) - longint'(hist[0])); m_dv = 1;
        end else begin
          m_delta = 33'd0; m_dv = 0;
        end
        hist.push_front(v);
        if (hist.size() > DEPTH) void'(hist.pop_back());
        m_fn = (m_fn + 1) % 65536;
      end
    end
    x.count = hist.size(); x.fn = m_fn; x.pv = m_peak; x.pf = m_pf;
    x.busy = m_busy; x.passed = m_passed; x.delta = m_delta; x.dv = m_dv;
    sq.push_back(x);
  endtask

  task automatic samp(input logic [31:0] v, input logic [2:0] d);
    cyc(0, 1, 1, v, 0, d, 0, 4'd0);
  endtask

  task automatic rd(input logic [3:0] a);
    cyc(0, 1, 0, 32'd0, 0, 3'd0, 1, a);
  endtask

  task automatic idle();
    cyc(0, 1, 0, 32'd0, 0, 3'd0, 0, 4'd0);
  endtask

  // Monitor: compares DUT outputs against popped expectations shortly after each edge
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sq.size() > 0) begin
        x = sq.pop_front();
        chk("count", 64'(count), 64'(x.count));
        chk("frame_num", 64'(frame_num), 64'(x.fn));
        chk("peak_val", 64'(peak_val), 64'(x.pv));
        chk("peak_frame", 64'(peak_frame), 64'(x.pf));
        chk("busy", 64'(busy), 64'(x.busy));
        chk("peak_passed", 64'(peak_passed), 64'(x.passed));
        chk("done", 64'(done), 64'(x.done));
        chk("rd_valid", 64'(rd_valid), 64'(x.rv));
`ifdef FOCUS_PEAK_DELTA_EN
        chk("delta", 64'(delta), 64'(x.delta));
        chk("delta_valid", 64'(delta_valid), 64'(x.dv));
`endif
      end
      if (rd_valid === 1'b1) begin
        if (rq.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL rd_unexpected: got rd_valid=1 expected no pending read");
        end else begin
          chk("rd_data", 64'(rd_data), 64'(rq.pop_front()));
        end
      end
    end
  end

  initial begin
    cyc(1, 0, 0, 32'd0, 0, 3'd0, 0, 4'd0);
    cyc(1, 0, 0, 32'd0, 0, 3'd0, 0, 4'd0);
    // Basic history fill and reads including beyond-count
    samp(32'd10, 3'd0); samp(32'd20, 3'd0); samp(32'd30, 3'd0);
    rd(4'd0); rd(4'd2); rd(4'd3); idle();
    // Wrap past DEPTH
    cyc(1, 0, 0, 32'd0, 0, 3'd0, 0, 4'd0);
    for (int i = 1; i <= 20; i++) samp(32'(i), 3'd0);
    rd(4'd0); rd(4'd15); idle();
    // Sweep with drop detection
    cyc(1, 0, 0, 32'd0, 0, 3'd0, 0, 4'd0);
    cyc(0, 1, 0, 32'd0, 1, 3'd2, 0, 4'd0);
    samp(32'd100, 3'd2); samp(32'd200, 3'd2); samp(32'd400, 3'd2);
    samp(32'd350, 3'd2); samp(32'd299, 3'd2); idle(); idle();
    // Detection disabled
    cyc(0, 1, 0, 32'd0, 1, 3'd0, 0, 4'd0);
    samp(32'd400, 3'd0); samp(32'd1, 3'd0); samp(32'd0, 3'd0); idle();
    // Equal sample keeps earliest frame; then pass, then arm+sample, then en=0
    cyc(0, 1, 0, 32'd0, 1, 3'd1, 0, 4'd0);
    samp(32'd400, 3'd1); samp(32'd400, 3'd1); samp(32'd100, 3'd1); idle();
    cyc(0, 1, 1, 32'd500, 1, 3'd1, 0, 4'd0);
    cyc(0, 0, 1, 32'd900, 0, 3'd1, 1, 4'd0);
    cyc(0, 0, 0, 32'd0, 1, 3'd1, 0, 4'd0);
    idle();
    // Delta pair then reset mid-stream
    samp(32'd300, 3'd0); samp(32'd100, 3'd0); idle();
    cyc(1, 1, 1, 32'd77, 0, 3'd0, 0, 4'd0);
    idle(); rd(4'd0); idle();
    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] v;
      v = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 1000)) : $urandom;
      cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) != 0),
          ($urandom_range(0, 1) == 1), v, ($urandom_range(0, 29) == 0),
          3'($urandom_range(0, 7)), ($urandom_range(0, 2) == 0),
          4'($urandom_range(0, 15)));
    end
    idle(); idle(); idle();
    @(posedge clk); #2;
    chk("rd_pending", 64'(rq.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
